bitwise_logic_unit: RTL

- Parametrised, registered bitwise logic unit for the ALU datapath. Supports 8 logic operations: AND, ORR, EOR, BIC, ORN, MVN, TST, TEQ.
- Valid/ready handshake on both sides, one result register stage.
- Holds a persistent N/Z flag register that is updated only by flag-setting operations.
- Replaces the fixed 32-bit AND-with-flags block in the bitwise methods group.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/logic_flags_calc.sv | 45 ++++
 rtl/bitwise_logic_unit.sv | 78 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic opcodes and the N/Z(/P) flag bundle.
// BLU_PARITY_EN adds the parity bit to the flag bundle.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_ORR = 3'b001,
    OP_EOR = 3'b010,
    OP_BIC = 3'b011,
    OP_ORN = 3'b100,
    OP_MVN = 3'b101,
    OP_TST = 3'b110,
    OP_TEQ = 3'b111
  } op_e;

  typedef struct packed {
    logic n;
    logic z;
`ifdef BLU_PARITY_EN
    logic p;
`endif
  } flags_t;

endpackage

// File: rtl/logic_flags_calc.sv
// Combinational logic op, flag derivation and write-back/flag-force decode.
// BLU_PARITY_EN adds the parity term to the flag bundle.
module logic_flags_calc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output flags_t           fl,
  output logic             wr,
  output logic             force_flags
);

  // Select the bitwise function for this opcode
  always_comb begin
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_ORR:  r = a | b;
      OP_EOR:  r = a ^ b;
      OP_BIC:  r = a & ~b;
      OP_ORN:  r = a | ~b;
      OP_MVN:  r = ~b;
      OP_TST:  r = a & b;
      OP_TEQ:  r = a ^ b;
      default: r = '0;
    endcase
  end

  // Derive flags from the result; TST/TEQ skip write-back but force flags
  always_comb begin
    fl   = '0;
    fl.n = r[WIDTH-1];
    fl.z = (r == '0);
`ifdef BLU_PARITY_EN
    fl.p = ^r;
`endif
    force_flags = (op[2:1] == 2'b11);
    wr          = !force_flags;
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with valid/ready handshake and N/Z flags.
// BLU_PARITY_EN adds the persistent parity flag output p.
module bitwise_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             wr_en,
  output logic             n,
  output logic             z
`ifdef BLU_PARITY_EN
  ,
  output logic             p
`endif
);

  logic [WIDTH-1:0] r;
  flags_t           fl;
  flags_t           flg;
  logic             wr;
  logic             force_flags;
  logic             fire;

  logic_flags_calc #(.WIDTH(WIDTH)) u_calc (
    .op          (op),
    .a           (a),
    .b           (b),
    .r           (r),
    .fl          (fl),
    .wr          (wr),
    .force_flags (force_flags)
  );

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;

  // Result stage: load on fire, drop valid once consumed, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      o         <= '0;
      wr_en     <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      o         <= r;
      wr_en     <= wr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Persistent flags: only S-suffixed ops and TST/TEQ update them
  always_ff @(posedge clk) begin
    if (rst) begin
      flg <= '0;
    end else if (fire && (set_flags || force_flags)) begin
      flg <= fl;
    end
  end

  assign n = flg.n;
  assign z = flg.z;
`ifdef BLU_PARITY_EN
  assign p = flg.p;
`endif

endmodule
